axis_pkt_gen: RTL and testbench

Synthesizable, parametrised AXI4-Stream packet generator that drives the MAC TX user interface (`tx_axis_*`) with configurable length, count, inter-packet gap, payload pattern and error injection. It replaces the behavioural stream master used in MAC loopback benches, so the same stimulus runs in simulation and on hardware. It sits between the control/register logic and the MAC TX AXI-stream port, in the TX user-clock domain.

---
 rtl/axis_gen_pkg.sv | 29 ++
 rtl/axis_pat_lane.sv | 26 ++
 rtl/axis_pkt_gen.sv | 233 +++++++++++++++++++++++
 tb/tb_axis_pkt_gen.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_gen_pkg.sv
// axis_gen_pkg: shared types and helpers for the AXI-Stream packet generator.
// Holds the FSM state type, the minimum Ethernet length and the last-beat keep helper.
package axis_gen_pkg;

  localparam int MIN_ETH_LEN = 60;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  // Keep mask for the final beat of a len-byte packet.
  // A zero remainder means the last beat is full.
  function automatic logic [15:0] last_keep(
    input logic [31:0] len,
    input int          keep_w
  );
    logic [31:0] rem;
    logic [15:0] m;
    rem = len % keep_w;
    if (rem == 32'd0)
      m = 16'((32'd1 << keep_w) - 32'd1);
    else
      m = 16'((32'd1 << rem) - 32'd1);
    return m;
  endfunction

endpackage

// File: rtl/axis_pat_lane.sv
// axis_pat_lane: builds one beat of payload across all byte lanes.
// In: pkt index, beat byte offset, mode, fill, keep. Out: beat data.
module axis_pat_lane
  import axis_gen_pkg::*;
#(
  parameter int KEEP_W = 8
) (
  input  logic [7:0]          pkt_i,
  input  logic [7:0]          off_i,
  input  logic                mode_i,
  input  logic [7:0]          fill_i,
  input  logic [KEEP_W-1:0]   keep_i,
  output logic [8*KEEP_W-1:0] data_o
);

  // Only the low 8 bits of index and offset matter: the byte wraps at 256.
  always_comb begin
    data_o = '0;
    for (int k = 0; k < KEEP_W; k++) begin
      if (keep_i[k])
        data_o[8*k +: 8] = mode_i ? fill_i
                                  : 8'(pkt_i + off_i + 8'(k));
    end
  end

endmodule

// File: rtl/axis_pkt_gen.sv
// axis_pkt_gen: AXI4-Stream packet generator for the MAC TX user port.
// In: clk/rst, start/stop, packet config. Out: m_axis_*, busy, done, pkt_sent.
module axis_pkt_gen
  import axis_gen_pkg::*;
#(
  parameter int DATA_W  = 64,
  parameter int KEEP_W  = DATA_W / 8,
  parameter int LEN_W   = 16,
  parameter int MIN_LEN = MIN_ETH_LEN
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic [LEN_W-1:0]  pkt_len_i,
  input  logic [31:0]       pkt_count_i,
  input  logic [7:0]        ifg_i,
  input  logic              pat_mode_i,
  input  logic [7:0]        fill_i,
  input  logic [7:0]        err_every_i,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic [KEEP_W-1:0] m_axis_tkeep,
  output logic              m_axis_tvalid,
  output logic              m_axis_tlast,
  output logic              m_axis_tuser,
  input  logic              m_axis_tready,
  output logic              busy_o,
  output logic              done_o,
  output logic [31:0]       pkt_sent_o
);

  localparam int KSH = $clog2(KEEP_W);

  state_e state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [31:0]       cnt_q, cnt_d;
  logic [7:0]        ifg_q, ifg_d;
  logic              mode_q, mode_d;
  logic [7:0]        fill_q, fill_d;
  logic [31:0]       pkt_q, pkt_d;
  logic [LEN_W-1:0]  beat_q, beat_d;
  logic [7:0]        gap_q, gap_d;
  logic [31:0]       sent_q, sent_d;
  logic [DATA_W-1:0] tdata_q, tdata_d;
  logic [KEEP_W-1:0] tkeep_q, tkeep_d;
  logic              tvalid_q, tvalid_d;
  logic              tlast_q, tlast_d;
  logic              tuser_q, tuser_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              hs, fin, load, sel_start;
  logic [31:0]       nxt_pkt;
  logic [LEN_W-1:0]  nxt_beat, eff_len, g_len;
  logic              g_mode, g_last, g_user;
  logic [7:0]        g_fill, g_off;
  logic [KEEP_W-1:0] g_keep;
  logic [DATA_W-1:0] g_data;

  assign hs  = tvalid_q & m_axis_tready;
  assign fin = ((cnt_q != 32'd0) && (pkt_q + 32'd1 == cnt_q))
             || stop_i;

  assign eff_len = (pkt_len_i < LEN_W'(MIN_LEN)) ? LEN_W'(MIN_LEN)
                                                 : pkt_len_i;

  // On the start cycle the beat is built from the live inputs,
  // afterwards from the latched copy.
  assign g_len  = sel_start ? eff_len    : len_q;
  assign g_mode = sel_start ? pat_mode_i : mode_q;
  assign g_fill = sel_start ? fill_i     : fill_q;

  assign g_last = nxt_beat == ((g_len - LEN_W'(1)) >> KSH);
  assign g_keep = g_last ? KEEP_W'(last_keep(32'(g_len), KEEP_W))
                         : '1;
  assign g_off  = 8'(nxt_beat << KSH);
  assign g_user = g_last && (err_every_i != 8'd0)
               && ((33'(nxt_pkt) + 33'd1) % 33'(err_every_i)
                   == 33'd0);

  axis_pat_lane #(
    .KEEP_W (KEEP_W)
  ) u_lane (
    .pkt_i  (8'(nxt_pkt)),
    .off_i  (g_off),
    .mode_i (g_mode),
    .fill_i (g_fill),
    .keep_i (g_keep),
    .data_o (g_data)
  );

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    ifg_d     = ifg_q;
    mode_d    = mode_q;
    fill_d    = fill_q;
    gap_d     = gap_q;
    sent_d    = sent_q;
    tvalid_d  = tvalid_q;
    done_d    = 1'b0;
    load      = 1'b0;
    sel_start = 1'b0;
    nxt_pkt   = pkt_q;
    nxt_beat  = beat_q + LEN_W'(1);
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          sel_start = 1'b1;
          load      = 1'b1;
          nxt_pkt   = 32'd0;
          nxt_beat  = '0;
          tvalid_d  = 1'b1;
          len_d     = eff_len;
          cnt_d     = pkt_count_i;
          ifg_d     = ifg_i;
          mode_d    = pat_mode_i;
          fill_d    = fill_i;
          state_d   = ST_SEND;
        end
      end
      ST_SEND: begin
        if (hs) begin
          if (!tlast_q) begin
            load = 1'b1;
          end else begin
            sent_d   = sent_q + 32'd1;
            nxt_pkt  = pkt_q + 32'd1;
            nxt_beat = '0;
            if (fin) begin
              tvalid_d = 1'b0;
              done_d   = 1'b1;
              state_d  = ST_IDLE;
            end else if (ifg_q != 8'd0) begin
              tvalid_d = 1'b0;
              gap_d    = ifg_q;
              state_d  = ST_GAP;
            end else begin
              load = 1'b1;
            end
          end
        end
      end
      ST_GAP: begin
        nxt_pkt  = pkt_q + 32'd1;
        nxt_beat = '0;
        if (stop_i) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (gap_q == 8'd1) begin
          load     = 1'b1;
          tvalid_d = 1'b1;
          state_d  = ST_SEND;
        end else begin
          gap_d = gap_q - 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output beat registers only change when a new beat is loaded,
  // which keeps them stable across a stall.
  always_comb begin
    tdata_d = tdata_q;
    tkeep_d = tkeep_q;
    tlast_d = tlast_q;
    tuser_d = tuser_q;
    pkt_d   = pkt_q;
    beat_d  = beat_q;
    if (load) begin
      tdata_d = g_data;
      tkeep_d = g_keep;
      tlast_d = g_last;
      tuser_d = g_user;
      pkt_d   = nxt_pkt;
      beat_d  = nxt_beat;
    end
  end

  assign busy_d = state_d != ST_IDLE;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= ST_IDLE;
      len_q    <= '0;
      cnt_q    <= '0;
      ifg_q    <= '0;
      mode_q   <= 1'b0;
      fill_q   <= '0;
      pkt_q    <= '0;
      beat_q   <= '0;
      gap_q    <= '0;
      sent_q   <= '0;
      tdata_q  <= '0;
      tkeep_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tuser_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      ifg_q    <= ifg_d;
      mode_q   <= mode_d;
      fill_q   <= fill_d;
      pkt_q    <= pkt_d;
      beat_q   <= beat_d;
      gap_q    <= gap_d;
      sent_q   <= sent_d;
      tdata_q  <= tdata_d;
      tkeep_q  <= tkeep_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      tuser_q  <= tuser_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tkeep  = tkeep_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tuser  = tuser_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign pkt_sent_o    = sent_q;

endmodule

// File: tb/tb_axis_pkt_gen.sv
// tb_axis_pkt_gen: 64- and 32-bit builds of axis_pkt_gen against a
// byte-level packet model; table rows, hand sequences and random runs.
module tb_axis_pkt_gen;

  localparam int LIM = 6000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i, stop64, stop32;
  logic [15:0] pkt_len_i;
  logic [31:0] pkt_count_i;
  logic [7:0]  ifg_i, fill_i, err_every_i;
  logic        pat_mode_i, tready;

  logic [63:0] td64;
  logic [7:0]  tk64;
  logic        tv64, tl64, tu64, busy64, done64;
  logic [31:0] sent64;
  logic [31:0] td32;
  logic [3:0]  tk32;
  logic        tv32, tl32, tu32, busy32, done32;
  logic [31:0] sent32;

  always #5 clk = ~clk;

  axis_pkt_gen #(.DATA_W(64)) dut64 (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start_i), .stop_i(stop64),
    .pkt_len_i(pkt_len_i), .pkt_count_i(pkt_count_i), .ifg_i(ifg_i),
    .pat_mode_i(pat_mode_i), .fill_i(fill_i), .err_every_i(err_every_i),
    .m_axis_tdata(td64), .m_axis_tkeep(tk64), .m_axis_tvalid(tv64),
    .m_axis_tlast(tl64), .m_axis_tuser(tu64), .m_axis_tready(tready),
    .busy_o(busy64), .done_o(done64), .pkt_sent_o(sent64)
  );

  axis_pkt_gen #(.DATA_W(32)) dut32 (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start_i), .stop_i(stop32),
    .pkt_len_i(pkt_len_i), .pkt_count_i(pkt_count_i), .ifg_i(ifg_i),
    .pat_mode_i(pat_mode_i), .fill_i(fill_i), .err_every_i(err_every_i),
    .m_axis_tdata(td32), .m_axis_tkeep(tk32), .m_axis_tvalid(tv32),
    .m_axis_tlast(tl32), .m_axis_tuser(tu32), .m_axis_tready(tready),
    .busy_o(busy32), .done_o(done32), .pkt_sent_o(sent32)
  );

  typedef struct {
    int          len;
    int          cnt;
    int          ifg;
    logic        mode;
    logic [7:0]  fill;
    int          err;
    int          rdy;
    int          pkts;
    int          b64;
    int          b32;
    logic        chk;
    logic [63:0] first64;
    logic [63:0] p1_64;
    logic [7:0]  lk64;
    logic [3:0]  lk32;
    logic [31:0] last32;
  } vec_t;

  vec_t tab[7];

  int vectors = 0;
  int miscompares = 0;
  int rdy_mode = 0;

  // model configuration for the current run
  int         m_len, m_ifg, m_err;
  logic       m_mode;
  logic [7:0] m_fill;

  // per-DUT monitor state (0 = 64-bit, 1 = 32-bit)
  int          mp[2], mb[2], beats[2], dones[2], gap_n[2];
  bit          gap_pend[2], stalled[2];
  logic [73:0] held[2];
  logic [63:0] first_d[2], p1_d[2], last_d[2];
  logic [7:0]  last_k[2];

  task automatic check(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic mon_clear();
    for (int i = 0; i < 2; i++) begin
      mp[i] = 0; mb[i] = 0; beats[i] = 0; dones[i] = 0; gap_n[i] = 0;
      gap_pend[i] = 0; stalled[i] = 0; held[i] = '0;
      first_d[i] = '0; p1_d[i] = '0; last_d[i] = '0; last_k[i] = '0;
    end
  endtask

  // Expected beat: byte i of packet p exists iff i < L; value is
  // (p+i) mod 256 or the fill byte.
  task automatic mon(input int id, input int kw, input logic tv,
                     input logic [63:0] td, input logic [7:0] tk,
                     input logic tl, input logic tu, input logic bz,
                     input logic dn);
    logic [73:0] cur;
    logic [63:0] ed;
    logic [7:0]  ek;
    logic        el, eu;
    int          len_eff, idx;
    cur = {td, tk, tl, tu};
    if (dn) dones[id]++;
    if (stalled[id])
      check($sformatf("stall_hold%0d", id), {tv, cur}, {1'b1, held[id]});
    stalled[id] = tv && !tready;
    held[id] = cur;
    if (gap_pend[id]) begin
      if (tv) begin
        check($sformatf("gap_len%0d", id), gap_n[id], m_ifg);
        gap_pend[id] = 0;
      end else if (!bz) begin
        gap_pend[id] = 0;
      end else begin
        gap_n[id]++;
      end
    end
    if (tv && tready) begin
      len_eff = (m_len < 60) ? 60 : m_len;
      ed = '0;
      ek = '0;
      for (int k = 0; k < kw; k++) begin
        idx = mb[id] * kw + k;
        if (idx < len_eff) begin
          ek[k] = 1'b1;
          ed[8*k +: 8] = m_mode ? m_fill : 8'((mp[id] + idx) % 256);
        end
      end
      el = (mb[id] + 1) * kw >= len_eff;
      eu = el && (m_err != 0) && (((mp[id] + 1) % m_err) == 0);
      check($sformatf("beat%0d p%0d b%0d", id, mp[id], mb[id]),
            cur, {ed, ek, el, eu});
      beats[id]++;
      if (mb[id] == 0 && mp[id] == 0) first_d[id] = td;
      if (mb[id] == 0 && mp[id] == 1) p1_d[id] = td;
      if (el) begin
        last_d[id] = td;
        last_k[id] = tk;
        mp[id]++;
        mb[id] = 0;
        gap_pend[id] = 1;
        gap_n[id] = 0;
      end else begin
        mb[id]++;
      end
    end
  endtask

  task automatic set_cfg(input vec_t v);
    pkt_len_i = 16'(v.len);
    pkt_count_i = 32'(v.cnt);
    ifg_i = 8'(v.ifg);
    pat_mode_i = v.mode;
    fill_i = v.fill;
    err_every_i = 8'(v.err);
    rdy_mode = v.rdy;
    m_len = v.len; m_ifg = v.ifg; m_err = v.err;
    m_mode = v.mode; m_fill = v.fill;
    mon_clear();
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start_i = 1'b1;
    @(posedge clk); #1 start_i = 1'b0;
  endtask

  task automatic run_cfg(input vec_t v, input string nm);
    logic [31:0] s64, s32;
    int t;
    set_cfg(v);
    s64 = sent64;
    s32 = sent32;
    pulse_start();
    // config changes and a second start while busy must be ignored
    pkt_len_i = 16'($urandom);
    ifg_i = 8'($urandom);
    fill_i = 8'($urandom);
    pat_mode_i = ~pat_mode_i;
    pkt_count_i = $urandom_range(1, 9);
    pulse_start();
    t = 0;
    while ((busy64 || busy32) && t < LIM) begin
      @(posedge clk); #1;
      t++;
    end
    check({nm, "_timeout"}, t < LIM, 1'b1);
    @(negedge clk); #1;
    check({nm, "_pkts64"}, sent64 - s64, v.pkts);
    check({nm, "_pkts32"}, sent32 - s32, v.pkts);
    check({nm, "_done64"}, dones[0], 1);
    check({nm, "_done32"}, dones[1], 1);
    check({nm, "_beats64"}, beats[0], v.b64);
    check({nm, "_beats32"}, beats[1], v.b32);
    if (v.chk) begin
      check({nm, "_first64"}, first_d[0], v.first64);
      check({nm, "_lkeep64"}, last_k[0], v.lk64);
      check({nm, "_lkeep32"}, last_k[1], v.lk32);
      check({nm, "_ldata32"}, last_d[1], v.last32);
      if (v.cnt > 1) check({nm, "_p1first64"}, p1_d[0], v.p1_64);
    end
  endtask

  task automatic run_stop(input int cnt, input int at_pkt, input int exp,
                          input string nm);
    vec_t v;
    logic [31:0] s64, s32;
    int t;
    v = '{default: 0};
    v.len = 10; v.cnt = cnt; v.err = 2;
    set_cfg(v);
    s64 = sent64;
    s32 = sent32;
    pulse_start();
    t = 0;
    while ((busy64 || busy32) && t < LIM) begin
      if (mp[0] == at_pkt && mb[0] >= 3) stop64 = 1'b1;
      if (mp[1] == at_pkt && mb[1] >= 3) stop32 = 1'b1;
      @(posedge clk); #1;
      t++;
    end
    check({nm, "_timeout"}, t < LIM, 1'b1);
    stop64 = 1'b0;
    stop32 = 1'b0;
    @(negedge clk); #1;
    check({nm, "_pkts64"}, sent64 - s64, exp);
    check({nm, "_pkts32"}, sent32 - s32, exp);
    check({nm, "_done64"}, dones[0], 1);
    check({nm, "_done32"}, dones[1], 1);
  endtask

  initial begin
    vec_t v;
    int len_eff;
    tab[0] = '{60, 1, 0, 1'b0, 8'h00, 0, 0, 1, 8, 15, 1'b1,
               64'h0706050403020100, 64'h0, 8'h0F, 4'hF, 32'h3B3A3938};
    tab[1] = '{60, 1, 0, 1'b0, 8'h00, 0, 1, 1, 8, 15, 1'b1,
               64'h0706050403020100, 64'h0, 8'h0F, 4'hF, 32'h3B3A3938};
    tab[2] = '{64, 3, 2, 1'b0, 8'h00, 0, 0, 3, 24, 48, 1'b1,
               64'h0706050403020100, 64'h0807060504030201,
               8'hFF, 4'hF, 32'h41403F3E};
    tab[3] = '{61, 1, 0, 1'b1, 8'hA5, 0, 0, 1, 8, 16, 1'b1,
               64'hA5A5A5A5A5A5A5A5, 64'h0, 8'h1F, 4'h1, 32'h000000A5};
    tab[4] = '{1500, 2, 0, 1'b0, 8'h00, 2, 2, 2, 376, 750, 1'b1,
               64'h0706050403020100, 64'h0807060504030201,
               8'h0F, 4'hF, 32'hDCDBDAD9};
    tab[5] = '{0, 1, 5, 1'b0, 8'h00, 1, 0, 1, 8, 15, 1'b1,
               64'h0706050403020100, 64'h0, 8'h0F, 4'hF, 32'h3B3A3938};
    tab[6] = '{200, 4, 1, 1'b0, 8'h00, 3, 1, 4, 100, 200, 1'b1,
               64'h0706050403020100, 64'h0807060504030201,
               8'hFF, 4'hF, 32'hCAC9C8C7};

    rst_n = 1'b0;
    start_i = 1'b0; stop64 = 1'b0; stop32 = 1'b0;
    pkt_len_i = '0; pkt_count_i = '0; ifg_i = '0;
    pat_mode_i = 1'b0; fill_i = '0; err_every_i = '0;
    tready = 1'b1;
    m_len = 60; m_ifg = 0; m_err = 0; m_mode = 1'b0; m_fill = '0;
    mon_clear();

    fork
      forever begin
        @(posedge clk); #1;
        if (rdy_mode == 0) tready = 1'b1;
        else if (rdy_mode == 1) tready = ~tready;
        else tready = 1'($urandom);
      end
      forever begin
        @(negedge clk);
        if (rst_n) begin
          mon(0, 8, tv64, td64, tk64, tl64, tu64, busy64, done64);
          mon(1, 4, tv32, {32'h0, td32}, {4'h0, tk32}, tl32, tu32,
              busy32, done32);
        end
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    check("rst64", {tv64, tl64, tu64, busy64, done64, td64, tk64, sent64}, '0);
    check("rst32", {tv32, tl32, tu32, busy32, done32, td32, tk32, sent32}, '0);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) run_cfg(tab[i], $sformatf("row%0d", i));

    run_stop(0, 4, 5, "stop_cont");
    run_stop(2, 1, 2, "stop_last");

    // asynchronous reset in the middle of a packet
    v = tab[0];
    v.cnt = 0;
    set_cfg(v);
    pulse_start();
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("rst_mid_tvalid64", tv64, 1'b0);
    check("rst_mid_tvalid32", tv32, 1'b0);
    check("rst_mid_state", {busy64, busy32, sent64, sent32}, '0);
    @(posedge clk); #1 rst_n = 1'b1;
    mon_clear();
    run_cfg(tab[0], "after_rst");

    for (int r = 0; r < 20; r++) begin
      v = '{default: 0};
      v.len = $urandom_range(0, 300);
      v.cnt = $urandom_range(1, 3);
      v.ifg = $urandom_range(0, 3);
      v.mode = 1'($urandom);
      v.fill = 8'($urandom);
      v.err = $urandom_range(0, 3);
      v.rdy = $urandom_range(0, 2);
      len_eff = (v.len < 60) ? 60 : v.len;
      v.pkts = v.cnt;
      v.b64 = v.cnt * ((len_eff + 7) / 8);
      v.b32 = v.cnt * ((len_eff + 3) / 4);
      v.chk = 1'b0;
      run_cfg(v, $sformatf("rand%0d", r));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
